// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Reader side of the instruction ROM. Owns the program counter, drives the
//   ROM address and hands the fetched instruction straight through to decode.
//   A Start/Done handshake frames one program run; during a run the next PC is
//   chosen from increment, absolute jump or relative branch, and a stall
//   freezes everything for the cycle. A saturating counter reports how many
//   instructions were retired since the last Start.
//
// Parameters
//   L          PC / ROM address width (ROM depth 2**L)
//   W          instruction width
//   START_ADDR PC loaded on reset and on every Start
//   CNT_W      retired-instruction counter width
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      begin program at START_ADDR (honoured in IDLE/DONE)
//   stall        in   1      hold PC, counter and state this cycle
//   halt         in   1      decode: current instruction is halt
//   branch_en    in   1      decode: take branch/jump this cycle
//   branch_abs   in   1      1: next PC = target, 0: next PC = PC + signed target
//   target       in   L      absolute address or two's-complement offset
//   inst_in      in   W      ROM data, combinational from inst_address
//   inst_address out  L      ROM address (= PC)
//   inst         out  W      instruction to decode (= inst_in)
//   inst_valid   out  1      inst is a live program instruction (RUN)
//   pc           out  L      current program counter
//   busy         out  1      state is RUN
//   done         out  1      state is DONE
//   inst_count   out  CNT_W  instructions retired since last Start
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int              L          = 8,
    parameter int              W          = 9,
    parameter logic [L-1:0]    START_ADDR = {L{1'b0}},
    parameter int              CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               halt,
    input  logic               branch_en,
    input  logic               branch_abs,
    input  logic [L-1:0]       target,
    input  logic [W-1:0]       inst_in,
    output logic [L-1:0]       inst_address,
    output logic [W-1:0]       inst,
    output logic               inst_valid,
    output logic [L-1:0]       pc,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   inst_count
);

    // Encoding 2'b11 is unused; the next-state logic steers it back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [L-1:0]       pc_r;
    logic [L-1:0]       pc_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // Next PC for a non-stalled, non-halting RUN cycle. Adding an L-bit
    // two's-complement offset in L bits is the same as adding its sign
    // extension and reducing modulo 2**L, so no explicit extension is needed.
    function automatic logic [L-1:0] next_pc(
        input logic [L-1:0] cur_pc,
        input logic         take_branch,
        input logic         absolute,
        input logic [L-1:0] tgt
    );
        logic [L-1:0] result;
        if (take_branch) begin
            if (absolute) begin
                result = tgt;
            end else begin
                result = cur_pc + tgt;
            end
        end else begin
            result = cur_pc + {{(L-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // Next-state, next-PC and next-count selection.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_RUN;
                    pc_s    = START_ADDR;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                // Priority: stall > halt > branch > increment; start is ignored.
                if (stall) begin
                    state_s = ST_RUN;
                end else if (halt) begin
                    // PC stays on the halt instruction.
                    state_s = ST_DONE;
                    cnt_s   = sat_inc(cnt_r);
                end else begin
                    pc_s    = next_pc(pc_r, branch_en, branch_abs, target);
                    cnt_s   = sat_inc(cnt_r);
                end
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = START_ADDR;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= START_ADDR;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            cnt_r   <= cnt_s;
        end
    end

    // Zero-cycle fetch: ROM address is the PC register, data passes straight through.
    assign inst_address = pc_r;
    assign inst         = inst_in;
    assign pc           = pc_r;
    assign inst_count   = cnt_r;

    // Status flags are pure decodes of the state register.
    assign busy       = (state_r == ST_RUN);
    assign inst_valid = (state_r == ST_RUN);
    assign done       = (state_r == ST_DONE);

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch. A directed table walks the main
//   next-PC rules, hand sequences cover Halt/Start and asynchronous reset,
//   and a long random run is compared against a behavioural model of the
//   fetch rules. The counter is instantiated narrow so saturation is reached.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int L     = 8;
    localparam int W     = 9;
    localparam int CNT_W = 5;
    localparam int CMAX  = 31;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stall;
    logic             halt;
    logic             branch_en;
    logic             branch_abs;
    logic [L-1:0]     target;
    logic [W-1:0]     inst_in;
    logic [L-1:0]     inst_address;
    logic [W-1:0]     inst;
    logic             inst_valid;
    logic [L-1:0]     pc;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] inst_count;

    logic [W-1:0]     rom [256];

    int checks;
    int errors;

    inst_fetch #(.L(L), .W(W), .START_ADDR(8'h00), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .halt         (halt),
        .branch_en    (branch_en),
        .branch_abs   (branch_abs),
        .target       (target),
        .inst_in      (inst_in),
        .inst_address (inst_address),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .inst_count   (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM.
    always_comb inst_in = rom[inst_address];

    typedef struct {
        logic [4:0] ctl;     // {start, stall, halt, branch_en, branch_abs}
        logic [7:0] tgt;
        logic [7:0] e_pc;
        logic [4:0] e_cnt;
        logic [1:0] e_bd;    // {busy, done}
    } vec_t;

    vec_t vec [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [7:0] tgt);
        {start, stall, halt, branch_en, branch_abs} = ctl;
        target = tgt;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic [7:0] e_pc,
                             input logic [4:0] e_cnt, input logic [1:0] e_bd);
        chk({name, ".pc"},      {24'd0, pc},           {24'd0, e_pc});
        chk({name, ".addr"},    {24'd0, inst_address}, {24'd0, e_pc});
        chk({name, ".count"},   {27'd0, inst_count},   {27'd0, e_cnt});
        chk({name, ".busy"},    {31'd0, busy},         {31'd0, e_bd[1]});
        chk({name, ".done"},    {31'd0, done},         {31'd0, e_bd[0]});
        chk({name, ".valid"},   {31'd0, inst_valid},   {31'd0, e_bd[1]});
        chk({name, ".inst"},    {23'd0, inst},         {23'd0, rom[e_pc]});
    endtask

    // Behavioural model state: mode 0 = idle, 1 = running, 2 = finished.
    int m_mode;
    int m_pc;
    int m_cnt;

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = W'($urandom);

        // Directed table, applied from IDLE after reset.
        vec[0]  = '{5'b10000, 8'h00, 8'h00, 5'd0,  2'b10}; // start
        vec[1]  = '{5'b00000, 8'h00, 8'h01, 5'd1,  2'b10}; // increment
        vec[2]  = '{5'b00011, 8'h10, 8'h10, 5'd2,  2'b10}; // absolute jump
        vec[3]  = '{5'b01011, 8'h80, 8'h10, 5'd2,  2'b10}; // stall beats branch
        vec[4]  = '{5'b01011, 8'h80, 8'h10, 5'd2,  2'b10};
        vec[5]  = '{5'b01011, 8'h80, 8'h10, 5'd2,  2'b10};
        vec[6]  = '{5'b00000, 8'h00, 8'h11, 5'd3,  2'b10}; // release
        vec[7]  = '{5'b00010, 8'hFC, 8'h0D, 5'd4,  2'b10}; // relative -4
        vec[8]  = '{5'b00011, 8'h02, 8'h02, 5'd5,  2'b10}; // jump to 0x02
        vec[9]  = '{5'b00010, 8'hFC, 8'hFE, 5'd6,  2'b10}; // 0x02-4 wraps to 0xFE
        vec[10] = '{5'b00000, 8'h00, 8'hFF, 5'd7,  2'b10};
        vec[11] = '{5'b00000, 8'h00, 8'h00, 5'd8,  2'b10}; // 0xFF+1 wraps
        vec[12] = '{5'b10000, 8'h00, 8'h01, 5'd9,  2'b10}; // start ignored in RUN
        vec[13] = '{5'b00111, 8'h55, 8'h01, 5'd10, 2'b01}; // halt beats branch
        vec[14] = '{5'b00011, 8'h55, 8'h01, 5'd10, 2'b01}; // DONE ignores branch
        vec[15] = '{5'b10000, 8'h00, 8'h00, 5'd0,  2'b10}; // restart
        vec[16] = '{5'b00010, 8'h23, 8'h23, 5'd1,  2'b10}; // relative +0x23

        rst_n = 1'b0;
        drive(5'b00000, 8'h00);
        #1;
        chk_state("reset", 8'h00, 5'd0, 2'b00);
        #13;
        rst_n = 1'b1;
        step();
        chk_state("idle_hold", 8'h00, 5'd0, 2'b00);

        for (int i = 0; i < 17; i++) begin
            drive(vec[i].ctl, vec[i].tgt);
            step();
            chk_state($sformatf("vec%0d", i), vec[i].e_pc, vec[i].e_cnt, vec[i].e_bd);
        end

        // Halt to DONE, restart, then five straight-line fetches.
        drive(5'b00100, 8'h00);
        step();
        chk_state("halt_0x23", 8'h23, 5'd2, 2'b01);
        drive(5'b10000, 8'h00);
        step();
        chk_state("restart", 8'h00, 5'd0, 2'b10);
        drive(5'b00000, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_state($sformatf("seq%0d", i), 8'(i), 5'(i), 2'b10);
        end

        // Halt at PC 0x07 after seven retired instructions.
        step();
        step();
        chk_state("at_0x07", 8'h07, 5'd7, 2'b10);
        drive(5'b00100, 8'h00);
        step();
        chk_state("halt_0x07", 8'h07, 5'd8, 2'b01);
        drive(5'b00000, 8'h00);
        step();
        chk_state("done_hold", 8'h07, 5'd8, 2'b01);
        drive(5'b10000, 8'h00);
        step();
        chk_state("start_from_done", 8'h00, 5'd0, 2'b10);

        // Asynchronous reset in the middle of a run at PC 0x23.
        drive(5'b00011, 8'h23);
        step();
        chk_state("pre_reset", 8'h23, 5'd1, 2'b10);
        drive(5'b00000, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_reset", 8'h00, 5'd0, 2'b00);
        #2;
        rst_n = 1'b1;
        step();
        chk_state("post_reset", 8'h00, 5'd0, 2'b00);

        // Random run against the behavioural model.
        m_mode = 0;
        m_pc   = 0;
        m_cnt  = 0;
        for (int n = 0; n < 3000; n++) begin
            logic s_start, s_stall, s_halt, s_br, s_abs;
            logic [7:0] s_tgt;
            int off;
            s_start = ($urandom_range(0, 9) == 0) || (m_mode != 1 && $urandom_range(0, 2) == 0);
            s_stall = ($urandom_range(0, 4) == 0);
            s_halt  = ($urandom_range(0, 59) == 0);
            s_br    = ($urandom_range(0, 5) == 0);
            s_abs   = $urandom_range(0, 1) == 1;
            s_tgt   = 8'($urandom);
            drive({s_start, s_stall, s_halt, s_br, s_abs}, s_tgt);

            if (m_mode == 1) begin
                if (!s_stall) begin
                    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                    if (s_halt) begin
                        m_mode = 2;
                    end else if (s_br) begin
                        off  = (s_tgt >= 8'd128) ? int'(s_tgt) - 256 : int'(s_tgt);
                        m_pc = s_abs ? int'(s_tgt) : (m_pc + off + 256) % 256;
                    end else begin
                        m_pc = (m_pc + 1) % 256;
                    end
                end
            end else if (s_start) begin
                m_mode = 1;
                m_pc   = 0;
                m_cnt  = 0;
            end

            step();
            chk_state($sformatf("rnd%0d", n), 8'(m_pc), 5'(m_cnt),
                      {m_mode == 1, m_mode == 2});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
